gb_irq_ctrl: RTL
================

# gb_irq_ctrl

Parametrised interrupt controller for the Game Boy core, replacing the fixed five-source IF/IE logic in the top level. It gathers N_SRC synchronous interrupt sources (vblank, LCD STAT, timer, serial, joypad, plus CGB/extension sources). It holds the IF and IE registers for CPU access and drives the CPU's `INT_n`. It also supplies a registered interrupt vector during the CPU's IORQ+M1 acknowledge cycle.

## Interface
- N_SRC, 5: number of interrupt sources; range 1..8.
- VEC_BASE, 8'h40: vector for source 0.
- VEC_STEP, 8'h08: vector spacing; vector(i) = (VEC_BASE + i·VEC_STEP) mod 256.
- VEC_NONE, 8'h55: vector returned when an acknowledge finds nothing pending.
- clk  in  1  system clock; this is the only clock.
- reset  in  1  synchronous, active-high reset.
- src  in  N_SRC  raw interrupt requests, synchronous to clk.
- cpu_sel_if  in  1  CPU address decodes to IF ($FF0F).
- cpu_sel_ie  in  1  CPU address decodes to IE ($FFFF).
- cpu_sel_mode  in  1  CPU address decodes to the mode register. Used only when the macro is defined; otherwise ignored.
- cpu_wr  in  1  CPU write strobe, active high.
- cpu_di  in  8  CPU write data.
- cpu_do  out  8  read data for the selected register.
- ack  in  1  CPU interrupt acknowledge (IORQ and M1 both active), level.
- irq_n  out  1  low while any enabled flag is pending.
- irq_vec  out  8  vector for the acknowledge cycle.

## Operation
- Registers:
  - if_r[N_SRC-1:0] is the flag register.
  - ie_r[N_SRC-1:0] is the enable register.
  - src_d[N_SRC-1:0] holds src delayed by one cycle.
- Flag set:
  - Edge-mode source i sets if_r[i] on src[i] & ~src_d[i].
  - Level-mode source i sets if_r[i] on every cycle that src[i] is high.
- irq_n = ~|(if_r & ie_r). This is combinational from the registers.
- Priority: the lowest index wins. Encoding is done in the sub-module.
- Acknowledge FSM:
  - IDLE → HOLD on an ack rising edge (ack & ~ack_d). In that cycle:
    - Latch pend = |(if_r & ie_r).
    - Latch idx = highest-priority pending enabled source.
    - Load irq_vec with vector(idx), or with VEC_NONE if pend = 0.
  - HOLD → IDLE when ack falls. In that cycle, if pend = 1, clear if_r[idx].
  - irq_vec stays stable for the whole of HOLD, even if flags change during it.
- Simultaneous events on one bit, lowest precedence first:
  1. Acknowledge clear.
  2. Source set.
  3. CPU write to IF.
  - A CPU write to IF replaces all bits.
  - The result: a new event arriving in the same cycle as the acknowledge clear survives.
- Reads:
  - IF reads as {ones in bits 7..N_SRC, if_r}.
  - IE reads as {zeros in bits 7..N_SRC, ie_r}.
  - With no select active, cpu_do = 8'hFF.
- Writes use cpu_di[N_SRC-1:0]; upper bits are ignored.

## Timing
- Reset values:
  - if_r = 0, ie_r = 0, src_d = 0.
  - FSM = IDLE.
  - irq_vec = VEC_NONE, irq_n = 1.
  - ack_d = 1, so an ack still held when reset releases is not taken as an edge.
- Source to irq_n: an edge on src at clock n sets if_r at edge n+1. irq_n is low after edge n+1, provided ie_r is set.
- Acknowledge: irq_vec is valid one clock after ack rises and holds until ack falls. The flag clears on the clock that samples ack low.
- Reset during HOLD: return to IDLE, clear flags, and perform no clear for the aborted acknowledge.
- N_SRC = 8 leaves no padding bits in IF or IE reads.

## Configuration
- GB_IRQ_EDGE_MODE_EN defined:
  - Adds an N_SRC-bit mode register, 1 = level and 0 = edge. Reset value is 0.
  - It is written and read through cpu_sel_mode; unused bits read as 0.
- GB_IRQ_EDGE_MODE_EN undefined: every source is edge-triggered, and cpu_sel_mode reads return 8'hFF.

## Structure
- Package gb_irq_pkg holds:
  - the FSM state enum (IRQ_IDLE, IRQ_HOLD);
  - default constants DEF_VEC_BASE, DEF_VEC_STEP, DEF_VEC_NONE;
  - MAX_SRC = 8.
- Sub-module gb_irq_prio is a parametrised lowest-index-first encoder. It outputs idx and a valid bit.

## Test plan
- Timer edge (N_SRC=5):
  - Stimulus: IE=8'h04, one-cycle pulse on src[2], then an ack pulse.
  - Response: irq_n low the next cycle; irq_vec=8'h50; IF reads 8'hE0 after ack falls; irq_n high.
- Priority:
  - Stimulus: IE=8'h1F; set src[3] and src[1] in the same cycle; acknowledge twice.
  - Response: vectors 8'h48 then 8'h58; IF ends at 8'hE0.
- Masked source:
  - Stimulus: IE=8'h00; src[0] pulses.
  - Response: IF=8'hE1, irq_n stays 1; an ack returns 8'h55 and IF stays 8'hE1.
- Collision:
  - Stimulus: during HOLD for source 0, pulse src[0] in the cycle ack falls.
  - Response: if_r[0] is still 1 afterwards.
- CPU write precedence:
  - Stimulus: write IF=8'h00 in the same cycle src[4] has an edge.
  - Response: IF reads 8'hE0.
- Reset mid-HOLD with ack held:
  - Stimulus: assert reset for one cycle while ack stays high.
  - Response: irq_vec=8'h55, IF=8'hE0, and no vector update until ack falls and rises again.
- Level mode (macro defined, N_SRC=8):
  - Stimulus: mode=8'h01, src[0] held high, IF written to 0.
  - Response: IF reads 8'h01 the next cycle.

Source files
------------

// File: rtl/gb_irq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gb_irq_pkg
// Purpose  : Shared types and constants for the Game Boy interrupt controller.
// Revision : 1.0 - initial release
// ============================================================================
package gb_irq_pkg;

    localparam int MAX_SRC = 8;
    localparam int IDX_W   = 3;

    localparam logic [7:0] DEF_VEC_BASE = 8'h40;
    localparam logic [7:0] DEF_VEC_STEP = 8'h08;
    localparam logic [7:0] DEF_VEC_NONE = 8'h55;

    typedef enum logic [0:0] {
        IRQ_IDLE = 1'b0,
        IRQ_HOLD = 1'b1
    } irq_state_e;

    // Vector arithmetic wraps modulo 256 through the 8-bit result width.
    function automatic logic [7:0] irq_vector(input logic [7:0]       base,
                                              input logic [7:0]       step,
                                              input logic [IDX_W-1:0] idx);
        return base + step * {5'd0, idx};
    endfunction

endpackage
`default_nettype wire

// File: rtl/gb_irq_prio.sv
`default_nettype none
// ============================================================================
// Module   : gb_irq_prio
// Purpose  : Lowest-index-first priority encoder with valid flag.
// Revision : 1.0 - initial release
// ============================================================================
module gb_irq_prio
    import gb_irq_pkg::*;
#(
    parameter int N_SRC = 5
) (
    input  logic [N_SRC-1:0] i_req,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    // Scanning downward lets the lowest set index overwrite all others.
    always_comb begin
        o_idx   = '0;
        o_valid = |i_req;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/gb_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gb_irq_ctrl
// Purpose  : IF/IE interrupt controller with INT_n and IM2-style vector reply.
//            GB_IRQ_EDGE_MODE_EN adds a per-source level/edge mode register.
// Revision : 1.0 - initial release
// ============================================================================
module gb_irq_ctrl
    import gb_irq_pkg::*;
#(
    parameter int         N_SRC    = 5,
    parameter logic [7:0] VEC_BASE = DEF_VEC_BASE,
    parameter logic [7:0] VEC_STEP = DEF_VEC_STEP,
    parameter logic [7:0] VEC_NONE = DEF_VEC_NONE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] src,
    input  logic             cpu_sel_if,
    input  logic             cpu_sel_ie,
    input  logic             cpu_sel_mode,
    input  logic             cpu_wr,
    input  logic [7:0]       cpu_di,
    output logic [7:0]       cpu_do,
    input  logic             ack,
    output logic             irq_n,
    output logic [7:0]       irq_vec
);

    localparam logic [N_SRC-1:0] c_ONE    = N_SRC'(1);
    localparam logic [7:0]       c_IF_PAD = 8'(9'h1FF << N_SRC);

    logic [N_SRC-1:0] r_if_q, w_if_d;
    logic [N_SRC-1:0] r_ie_q, w_ie_d;
    logic [N_SRC-1:0] r_src_q;
    logic [N_SRC-1:0] w_level, w_set, w_clr, w_pend_mask;
    logic             r_ack_q;
    irq_state_e       r_state_q, w_state_d;
    logic             r_pend_q, w_pend_d;
    logic [IDX_W-1:0] r_idx_q, w_idx_d, w_prio_idx;
    logic             w_prio_valid;
    logic [7:0]       r_vec_q, w_vec_d;
    logic             w_unused;

    assign w_unused = &{1'b0, cpu_di, cpu_sel_mode};

`ifdef GB_IRQ_EDGE_MODE_EN
    logic [N_SRC-1:0] r_mode_q, w_mode_d;

    always_comb begin
        w_mode_d = r_mode_q;
        if (cpu_wr && cpu_sel_mode) begin
            w_mode_d = cpu_di[N_SRC-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode_q <= '0;
        end else begin
            r_mode_q <= w_mode_d;
        end
    end

    assign w_level = r_mode_q;
`else
    assign w_level = '0;
`endif

    assign w_set       = (src & ~r_src_q & ~w_level) | (src & w_level);
    assign w_pend_mask = r_if_q & r_ie_q;
    assign irq_n       = ~|w_pend_mask;
    assign irq_vec     = r_vec_q;

    gb_irq_prio #(
        .N_SRC (N_SRC)
    ) u_prio (
        .i_req   (w_pend_mask),
        .o_idx   (w_prio_idx),
        .o_valid (w_prio_valid)
    );

    // Acknowledge FSM: decision and vector are frozen at the ack rising edge.
    always_comb begin
        w_state_d = r_state_q;
        w_pend_d  = r_pend_q;
        w_idx_d   = r_idx_q;
        w_vec_d   = r_vec_q;
        w_clr     = '0;
        case (r_state_q)
            IRQ_IDLE: begin
                if (ack && !r_ack_q) begin
                    w_state_d = IRQ_HOLD;
                    w_pend_d  = w_prio_valid;
                    w_idx_d   = w_prio_idx;
                    w_vec_d   = w_prio_valid ? irq_vector(VEC_BASE, VEC_STEP, w_prio_idx)
                                             : VEC_NONE;
                end
            end
            IRQ_HOLD: begin
                if (!ack) begin
                    w_state_d = IRQ_IDLE;
                    if (r_pend_q) begin
                        w_clr = c_ONE << r_idx_q;
                    end
                end
            end
            default: w_state_d = IRQ_IDLE;
        endcase
    end

    // Precedence low to high: ack clear, source set, CPU write.
    always_comb begin
        w_if_d = (r_if_q & ~w_clr) | w_set;
        if (cpu_wr && cpu_sel_if) begin
            w_if_d = cpu_di[N_SRC-1:0];
        end
        w_ie_d = r_ie_q;
        if (cpu_wr && cpu_sel_ie) begin
            w_ie_d = cpu_di[N_SRC-1:0];
        end
    end

    always_comb begin
        cpu_do = 8'hFF;
        if (cpu_sel_if) begin
            cpu_do = 8'(r_if_q) | c_IF_PAD;
        end else if (cpu_sel_ie) begin
            cpu_do = 8'(r_ie_q);
        end
`ifdef GB_IRQ_EDGE_MODE_EN
        else if (cpu_sel_mode) begin
            cpu_do = 8'(r_mode_q);
        end
`endif
    end

    // ack history resets high so an ack held through reset is not an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_if_q    <= '0;
            r_ie_q    <= '0;
            r_src_q   <= '0;
            r_ack_q   <= 1'b1;
            r_state_q <= IRQ_IDLE;
            r_pend_q  <= 1'b0;
            r_idx_q   <= '0;
            r_vec_q   <= VEC_NONE;
        end else begin
            r_if_q    <= w_if_d;
            r_ie_q    <= w_ie_d;
            r_src_q   <= src;
            r_ack_q   <= ack;
            r_state_q <= w_state_d;
            r_pend_q  <= w_pend_d;
            r_idx_q   <= w_idx_d;
            r_vec_q   <= w_vec_d;
        end
    end

endmodule
`default_nettype wire
